uart_ctrl: RTL and testbench

Bus-facing controller that sequences one UART transmitter core and one UART receiver core. It buffers outgoing and incoming bytes in two synchronous FIFOs and exposes a three-register CPU port with status and an interrupt. It sits between the system bus decoder and the bit-level UART cores, which keep their own baud timing and have no reset.

---
 rtl/uart_ctrl_pkg.sv | 38 +++
 rtl/uart_fifo.sv | 68 ++++++
 rtl/uart_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Register map, STATUS/CTRL bit positions and CTRL layout
//                shared by the UART controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Register select values on addr
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_COUNT_LSB = 0;
    localparam int ST_TX_COUNT_LSB = 8;
    localparam int ST_RX_OVR       = 16;
    localparam int ST_TX_OVF       = 17;
    localparam int ST_TX_BUSY      = 18;
    localparam int ST_TX_IDLE      = 19;

    // CTRL bit positions
    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TX_IE  = 1;
    localparam int CTRL_ERR_IE = 2;
    localparam int CTRL_CLR    = 8;

    // Stored CTRL bits; bit order matches CTRL_*_IE positions
    typedef struct packed {
        logic err_ie;
        logic tx_ie;
        logic rx_ie;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous FIFO, 2^DEPTH_LOG2 entries, combinational head.
//                Push and pop in the same cycle both succeed whenever the
//                FIFO holds a valid head, even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == C_FULL);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop needs a valid head; a push into a full FIFO is fine if the head leaves
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl
//  Description : CPU-facing UART controller. Buffers TX and RX bytes in two
//                FIFOs, exposes DATA/STATUS/CTRL registers and a level irq,
//                and hands bytes to / from the bit-level UART cores.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  tx_din,
    output logic        tx_ready,
    input  logic        tx_ack,
    input  logic        tx_busy,
    input  logic [7:0]  rx_dout,
    input  logic        rx_ready
);

    logic                r_ack_q;
    logic                r_rdy_q;
    ctrl_t               r_ctrl;
    logic                r_rx_ovr;
    logic                r_tx_ovf;
    logic [31:0]         r_rdata;
    logic                r_irq;

    logic                w_tx_pop_ev;
    logic                w_rx_push_ev;
    logic                w_data_wr;
    logic                w_data_rd;
    logic                w_ctrl_wr;
    logic                w_clr;
    logic                w_rx_pop;
    logic                w_rx_ovr_set;
    logic                w_tx_ovf_set;
    logic                w_irq_next;
    logic [31:0]         w_status;
    logic                w_unused_wdata;

    logic [7:0]          w_tx_head;
    logic [DEPTH_LOG2:0] w_tx_count;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic [7:0]          w_rx_head;
    logic [DEPTH_LOG2:0] w_rx_count;
    logic                w_rx_full;
    logic                w_rx_empty;

    // Edge detectors: one FIFO action per core handshake pulse
    assign w_tx_pop_ev  = tx_ack   & ~r_ack_q;
    assign w_rx_push_ev = rx_ready & ~r_rdy_q;

    assign w_data_wr = we & (addr == ADDR_DATA);
    assign w_data_rd = re & (addr == ADDR_DATA);
    assign w_ctrl_wr = we & (addr == ADDR_CTRL);
    assign w_clr     = w_ctrl_wr & wdata[CTRL_CLR];
    assign w_rx_pop  = w_data_rd & ~w_rx_empty;

    // A byte is lost only if the FIFO is full and nothing leaves this cycle
    assign w_rx_ovr_set = w_rx_push_ev & w_rx_full & ~w_rx_pop;
    assign w_tx_ovf_set = w_data_wr    & w_tx_full & ~w_tx_pop_ev;

    assign w_unused_wdata = ^wdata[31:9];

    uart_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_data_wr),
        .pop   (w_tx_pop_ev),
        .din   (wdata[7:0]),
        .dout  (w_tx_head),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    uart_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push_ev),
        .pop   (w_rx_pop),
        .din   (rx_dout),
        .dout  (w_rx_head),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // Stale storage never reaches the TX core: head is masked while empty
    assign tx_din   = w_tx_empty ? 8'h00 : w_tx_head;
    assign tx_ready = ~w_tx_empty;

    // STATUS word assembly
    always_comb begin
        w_status = '0;
        w_status[ST_RX_COUNT_LSB +: DEPTH_LOG2 + 1] = w_rx_count;
        w_status[ST_TX_COUNT_LSB +: DEPTH_LOG2 + 1] = w_tx_count;
        w_status[ST_RX_OVR]  = r_rx_ovr;
        w_status[ST_TX_OVF]  = r_tx_ovf;
        w_status[ST_TX_BUSY] = tx_busy;
        w_status[ST_TX_IDLE] = w_tx_empty & ~tx_busy;
    end

    assign w_irq_next = (r_ctrl.rx_ie  & ~w_rx_empty)
                      | (r_ctrl.tx_ie  &  w_tx_empty)
                      | (r_ctrl.err_ie & (r_rx_ovr | r_tx_ovf));

    // Previous handshake levels; reset high so levels held across reset are not edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_q <= 1'b1;
            r_rdy_q <= 1'b1;
        end else begin
            r_ack_q <= tx_ack;
            r_rdy_q <= rx_ready;
        end
    end

    // CTRL enables and sticky error flags; a new overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= '0;
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= ctrl_t'(wdata[2:0]);
            if (w_rx_ovr_set)  r_rx_ovr <= 1'b1;
            else if (w_clr)    r_rx_ovr <= 1'b0;
            if (w_tx_ovf_set)  r_tx_ovf <= 1'b1;
            else if (w_clr)    r_tx_ovf <= 1'b0;
        end
    end

    // Registered read data (held between reads) and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= w_irq_next;
            if (re) begin
                case (addr)
                    ADDR_DATA:   r_rdata <= w_rx_empty ? 32'h0 : {23'b0, 1'b1, w_rx_head};
                    ADDR_STATUS: r_rdata <= w_status;
                    ADDR_CTRL:   r_rdata <= {29'b0, r_ctrl};
                    default:     r_rdata <= 32'h0;
                endcase
            end
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_ctrl
//  Description : Self-checking bench for uart_ctrl: directed vector table,
//                hand-written corner sequences and randomized traffic, all
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  tx_din;
    logic        tx_ready;
    logic        tx_ack = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_dout = 8'h0;
    logic        rx_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .tx_din   (tx_din),
        .tx_ready (tx_ready),
        .tx_ack   (tx_ack),
        .tx_busy  (tx_busy),
        .rx_dout  (rx_dout),
        .rx_ready (rx_ready)
    );

    // ---------------- reference model (queues + flags) ----------------
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    bit          m_rx_ovr, m_tx_ovf;
    logic [2:0]  m_ctrl;
    bit          m_ackq, m_rdyq;
    logic [31:0] m_rdata;
    bit          m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_rx_ovr = 0; m_tx_ovf = 0; m_ctrl = 3'b0;
        m_ackq = 1; m_rdyq = 1;
        m_rdata = 32'h0; m_irq = 0;
    endtask

    task automatic model_step();
        bit tx_ev, rx_ev, irq_next, set_ovr, set_ovf;
        tx_ev = tx_ack && !m_ackq;
        rx_ev = rx_ready && !m_rdyq;
        irq_next = (m_ctrl[0] && m_rxq.size() > 0) || (m_ctrl[1] && m_txq.size() == 0)
                || (m_ctrl[2] && (m_rx_ovr || m_tx_ovf));
        set_ovr = 0; set_ovf = 0;
        if (re) begin
            case (addr)
                2'd0: begin
                    if (m_rxq.size() > 0) begin
                        m_rdata = 32'h100 | 32'(m_rxq[0]);
                        void'(m_rxq.pop_front());
                    end else m_rdata = 32'h0;
                end
                2'd1: m_rdata = 32'(m_rxq.size()) | (32'(m_txq.size()) << 8)
                              | (32'(m_rx_ovr) << 16) | (32'(m_tx_ovf) << 17)
                              | (32'(tx_busy) << 18)
                              | (32'(m_txq.size() == 0 && !tx_busy) << 19);
                2'd2: m_rdata = {29'b0, m_ctrl};
                default: m_rdata = 32'h0;
            endcase
        end
        if (rx_ev) begin
            if (m_rxq.size() < DEPTH) m_rxq.push_back(rx_dout);
            else set_ovr = 1;
        end
        if (tx_ev && m_txq.size() > 0) void'(m_txq.pop_front());
        if (we && addr == 2'd0) begin
            if (m_txq.size() < DEPTH) m_txq.push_back(wdata[7:0]);
            else set_ovf = 1;
        end
        if (we && addr == 2'd2) begin
            m_ctrl = wdata[2:0];
            if (wdata[8]) begin m_rx_ovr = 0; m_tx_ovf = 0; end
        end
        if (set_ovr) m_rx_ovr = 1;
        if (set_ovf) m_tx_ovf = 1;
        m_ackq = tx_ack;
        m_rdyq = rx_ready;
        m_irq = irq_next;
    endtask

    // One clock: advance model with current inputs, then compare visible outputs
    task automatic tick();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        check("rdata", rdata, m_rdata);
        check("irq", 32'(irq), 32'(m_irq));
        check("tx_ready", 32'(tx_ready), 32'(m_txq.size() > 0));
        check("tx_din", 32'(tx_din), (m_txq.size() > 0) ? 32'(m_txq[0]) : 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        tick();
        re = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_dout = b; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we, re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        ack, rdy;
        logic [7:0]  rxd;
        logic [31:0] e_rdata;
        logic        e_irq, e_rdy;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [31:0] d;

        vt[0]  = '{1'b0, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 8'h00, 32'h000, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 2'd0, 32'h041, 1'b0, 1'b0, 8'h00, 32'h000, 1'b0, 1'b1, 8'h41};
        vt[2]  = '{1'b1, 1'b0, 2'd2, 32'h002, 1'b0, 1'b0, 8'h00, 32'h000, 1'b0, 1'b1, 8'h41};
        vt[3]  = '{1'b0, 1'b1, 2'd1, 32'h000, 1'b0, 1'b0, 8'h00, 32'h100, 1'b0, 1'b1, 8'h41};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h000, 1'b1, 1'b0, 8'h00, 32'h100, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 32'h000, 1'b1, 1'b0, 8'h00, 32'h100, 1'b1, 1'b0, 8'h00};
        vt[6]  = '{1'b0, 1'b1, 2'd2, 32'h000, 1'b0, 1'b0, 8'h00, 32'h002, 1'b1, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 32'h000, 1'b0, 1'b1, 8'h5A, 32'h002, 1'b1, 1'b0, 8'h00};
        vt[8]  = '{1'b0, 1'b1, 2'd0, 32'h000, 1'b0, 1'b1, 8'h00, 32'h15A, 1'b1, 1'b0, 8'h00};
        vt[9]  = '{1'b0, 1'b1, 2'd0, 32'h000, 1'b0, 1'b0, 8'h00, 32'h000, 1'b1, 1'b0, 8'h00};
        vt[10] = '{1'b1, 1'b0, 2'd2, 32'h000, 1'b0, 1'b0, 8'h00, 32'h000, 1'b1, 1'b0, 8'h00};
        vt[11] = '{1'b0, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 8'h00, 32'h000, 1'b0, 1'b0, 8'h00};
        vt[12] = '{1'b0, 1'b1, 2'd3, 32'h000, 1'b0, 1'b0, 8'h00, 32'h000, 1'b0, 1'b0, 8'h00};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_tx_ready", 32'(tx_ready), 32'h0);
        check("reset_tx_din", 32'(tx_din), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            we = vt[i].we; re = vt[i].re; addr = vt[i].addr; wdata = vt[i].wdata;
            tx_ack = vt[i].ack; rx_ready = vt[i].rdy; rx_dout = vt[i].rxd;
            tick();
            check($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].e_irq));
            check($sformatf("vec%0d_tx_ready", i), 32'(tx_ready), 32'(vt[i].e_rdy));
            check($sformatf("vec%0d_tx_din", i), 32'(tx_din), 32'(vt[i].e_din));
        end
        we = 0; re = 0; tx_ack = 0; rx_ready = 0;

        // TX queueing
        rst = 1'b1; tick(); rst = 1'b0;
        wr(2'd0, 32'h41); wr(2'd0, 32'h42); wr(2'd0, 32'h43);
        check("txq_head0", 32'(tx_din), 32'h41);
        rd(2'd1, d);
        check("txq_status3", d, 32'h0000_0300);
        tick();
        check("txq_hold", 32'(tx_din), 32'h41);
        pulse_ack();
        check("txq_head1", 32'(tx_din), 32'h42);
        pulse_ack();
        check("txq_head2", 32'(tx_din), 32'h43);
        pulse_ack();
        check("txq_ready_low", 32'(tx_ready), 32'h0);
        rd(2'd1, d);
        check("txq_status0", d, 32'h0008_0000);

        // RX overrun
        for (int i = 0; i < 17; i++) pulse_rx(8'(i));
        rd(2'd1, d);
        check("rxovr_status", d, 32'h0009_0010);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, d);
            check($sformatf("rxovr_read%0d", i), d, 32'h100 + 32'(i));
        end
        rd(2'd0, d);
        check("rxovr_read_empty", d, 32'h0);
        wr(2'd2, 32'h100);

        // TX overflow
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) wr(2'd0, 32'h60 + 32'(i));
        rd(2'd1, d);
        check("txovf_status", d, 32'h0006_1000);
        wr(2'd2, 32'h100);
        rd(2'd1, d);
        check("txovf_cleared", d, 32'h0004_1000);
        for (int i = 0; i < 16; i++) pulse_ack();
        tx_busy = 1'b0;

        // Simultaneous push/pop on a full RX FIFO
        for (int i = 0; i < 16; i++) pulse_rx(8'h20 + 8'(i));
        rx_dout = 8'h99; rx_ready = 1'b1;
        rd(2'd0, d);
        check("simul_rdata", d, 32'h120);
        rx_ready = 1'b0;
        rd(2'd1, d);
        check("simul_status", d, 32'h0008_0010);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, d);
            if (i == 0)  check("simul_next", d, 32'h121);
            if (i == 15) check("simul_last", d, 32'h199);
        end

        // Interrupt enables
        wr(2'd2, 32'h1);
        tick();
        check("irq_rx_empty", 32'(irq), 32'h0);
        rx_dout = 8'h77; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        check("irq_rx_byte", 32'(irq), 32'h1);
        rd(2'd0, d);
        check("irq_rx_data", d, 32'h177);
        tick();
        check("irq_rx_drop", 32'(irq), 32'h0);
        wr(2'd2, 32'h2);
        tick();
        check("irq_tx_empty", 32'(irq), 32'h1);

        // Reset mid-operation with handshake levels held high
        wr(2'd0, 32'hA1); wr(2'd0, 32'hA2);
        pulse_rx(8'hB1); pulse_rx(8'hB2);
        wr(2'd2, 32'h7);
        tx_ack = 1'b1; rx_ready = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("rstmid_irq", 32'(irq), 32'h0);
        check("rstmid_tx_ready", 32'(tx_ready), 32'h0);
        rd(2'd1, d);
        check("rstmid_status", d, 32'h0008_0000);
        tx_ack = 1'b0; rx_ready = 1'b0;
        tick();
        rd(2'd1, d);
        check("rstmid_status2", d, 32'h0008_0000);

        // Randomized traffic: fill-biased phase then drain-biased phase
        for (int n = 0; n < 4000; n++) begin
            bit fill;
            fill = (n % 1000) < 500;
            we = ($urandom_range(0, 2) == 0);
            re = fill ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
            addr = 2'($urandom_range(0, 3));
            if (we && addr == 2'd2) wdata = $urandom() & 32'h0000_01FF;
            else wdata = $urandom();
            if ($urandom_range(0, fill ? 7 : 2) == 0) tx_ack = ~tx_ack;
            if ($urandom_range(0, 2) == 0) rx_ready = ~rx_ready;
            rx_dout = 8'($urandom());
            if ($urandom_range(0, 9) == 0) tx_busy = ~tx_busy;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        we = 0; re = 0; rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
